// File: rtl/hazard_ctrl_unit.sv
// Forwarding selects and pipeline hazard control for the 5-stage core.
// Forwarding and stall/flush outputs are combinational from the registered FSM state; stall_count is registered.
module hazard_ctrl_unit #(
  parameter int RA_W     = 3,
  parameter int MEM_LAT  = 0,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic            id_branch,
  input  logic            jump_taken,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_valid,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic            mem_memwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd1_ex,
  output logic [1:0]      fwd2_ex,
  output logic [1:0]      bfwd1,
  output logic [1:0]      bfwd2,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            bubble_idex,
  output logic            stall_idex,
  output logic            stall_exmem,
  output logic            bubble_memwb,
  output logic            flush_ifid,
  output logic [15:0]     stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam bit         HAS_WAIT  = (MEM_LAT > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic        mem_access;
  logic        ex_m1, ex_m2, mem_m1, mem_m2;
  logic        lu_hz, br_ex_hz, br_ld_hz, br_mem_hz;
  logic        frz, hz;

  function automatic logic match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] rd,
                                 input logic we, input logic v);
    return v && we && (a == rd) && !(ZERO_REG && (rd == '0));
  endfunction

  // A load in MEM has no data yet, so it never forwards from MEM.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] a);
    if (match(a, mem_rd, mem_regwrite, mem_valid) && !mem_memread) return 2'b01;
    if (match(a, wb_rd, wb_regwrite, 1'b1))                        return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    ex_m1      = match(id_rs1, ex_rd, ex_regwrite, ex_valid);
    ex_m2      = match(id_rs2, ex_rd, ex_regwrite, ex_valid);
    mem_m1     = match(id_rs1, mem_rd, mem_regwrite, mem_valid);
    mem_m2     = match(id_rs2, mem_rd, mem_regwrite, mem_valid);
    lu_hz      = id_valid && ex_memread && ((id_use1 && ex_m1) || (id_use2 && ex_m2));
    br_ex_hz   = id_valid && id_branch && !ex_memread && (ex_m1 || ex_m2);
    br_ld_hz   = id_valid && id_branch && ex_memread && (ex_m1 || ex_m2);
    br_mem_hz  = id_valid && id_branch && mem_memread && (mem_m1 || mem_m2);
    mem_access = HAS_WAIT && mem_valid && (mem_memread || mem_memwrite);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frz     = 1'b0;
    hz      = 1'b0;
    if (!reset) begin
      case (state_q)
        MEM_WAIT: begin
          frz = (cnt_q != 4'd0);
          if (cnt_q == 4'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        BR_HOLD: begin
          if (mem_access) begin
            frz     = 1'b1;
            cnt_d   = WAIT_LOAD;
            state_d = MEM_WAIT;
          end else begin
            // Second cycle of a load->branch hazard: the producer now sits in MEM.
            hz      = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          if (mem_access) begin
            frz     = 1'b1;
            cnt_d   = WAIT_LOAD;
            state_d = MEM_WAIT;
          end else begin
            hz = lu_hz || br_ex_hz || br_ld_hz || br_mem_hz;
            if (br_ld_hz) state_d = BR_HOLD;
          end
        end
      endcase
    end
  end

  always_comb begin
    fwd1_ex = 2'b00;
    fwd2_ex = 2'b00;
    bfwd1   = 2'b00;
    bfwd2   = 2'b00;
    if (!reset) begin
      fwd1_ex = fwd_sel(ex_rs1);
      fwd2_ex = fwd_sel(ex_rs2);
      bfwd1   = fwd_sel(id_rs1);
      bfwd2   = fwd_sel(id_rs2);
    end
  end

  assign stall_pc     = frz || hz;
  assign stall_ifid   = frz || hz;
  assign bubble_idex  = hz && !frz;
  assign stall_idex   = frz;
  assign stall_exmem  = frz;
  assign bubble_memwb = frz;
  assign flush_ifid   = !reset && jump_taken && !stall_ifid;
  assign stall_count  = stall_count_q;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_pc && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: two instances (MEM_LAT=0/ZERO_REG=1 and MEM_LAT=3/ZERO_REG=0) share stimulus.
module tb_hazard_ctrl_unit;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_use1, id_use2, id_branch, jump_taken;
  logic [2:0] id_rs1, id_rs2;
  logic       ex_valid, ex_regwrite, ex_memread;
  logic [2:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [2:0] mem_rd;
  logic       wb_regwrite;
  logic [2:0] wb_rd;

  logic [1:0]  f1_0, f2_0, b1_0, b2_0, f1_3, f2_3, b1_3, b2_3;
  logic        spc_0, sif_0, bid_0, sid_0, sem_0, bmw_0, fl_0;
  logic        spc_3, sif_3, bid_3, sid_3, sem_3, bmw_3, fl_3;
  logic [15:0] cnt_0, cnt_3;

  hazard_ctrl_unit #(.RA_W(3), .MEM_LAT(0), .ZERO_REG(1'b1)) u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_branch(id_branch), .jump_taken(jump_taken),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fwd1_ex(f1_0), .fwd2_ex(f2_0), .bfwd1(b1_0), .bfwd2(b2_0),
    .stall_pc(spc_0), .stall_ifid(sif_0), .bubble_idex(bid_0), .stall_idex(sid_0),
    .stall_exmem(sem_0), .bubble_memwb(bmw_0), .flush_ifid(fl_0), .stall_count(cnt_0));

  hazard_ctrl_unit #(.RA_W(3), .MEM_LAT(3), .ZERO_REG(1'b0)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_branch(id_branch), .jump_taken(jump_taken),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fwd1_ex(f1_3), .fwd2_ex(f2_3), .bfwd1(b1_3), .bfwd2(b2_3),
    .stall_pc(spc_3), .stall_ifid(sif_3), .bubble_idex(bid_3), .stall_idex(sid_3),
    .stall_exmem(sem_3), .bubble_memwb(bmw_3), .flush_ifid(fl_3), .stall_count(cnt_3));

  // Status bit order: stall_pc stall_ifid bubble_idex stall_idex stall_exmem bubble_memwb flush_ifid
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_HZ   = 7'b1110000;
  localparam logic [6:0] S_FRZ  = 7'b1101110;
  localparam logic [6:0] S_FL   = 7'b0000001;

  logic [30:0] act0, act3;
  assign act0 = {f1_0, f2_0, b1_0, b2_0, spc_0, sif_0, bid_0, sid_0, sem_0, bmw_0, fl_0, cnt_0};
  assign act3 = {f1_3, f2_3, b1_3, b2_3, spc_3, sif_3, bid_3, sid_3, sem_3, bmw_3, fl_3, cnt_3};

  typedef struct {
    string       name;
    bit          sel;
    logic [30:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_t        e;
    logic [30:0] a;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        a = e.sel ? act3 : act0;
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s dut%0d fwd/bfwd got %b want %b status got %b want %b count got %0d want %0d",
                   e.name, e.sel ? 3 : 0, a[30:23], e.exp[30:23], a[22:16], e.exp[22:16],
                   a[15:0], e.exp[15:0]);
        end
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_branch = 0; jump_taken = 0;
    id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_valid = 0; mem_regwrite = 0; mem_memread = 0; mem_memwrite = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0;
  endtask

  task automatic step(input string nm, input bit sel, input logic [1:0] f1, input logic [1:0] f2,
                      input logic [1:0] b1, input logic [1:0] b2, input logic [6:0] st,
                      input logic [15:0] c);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = {f1, f2, b1, b2, st, c};
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic nochk();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load(input logic [2:0] rd);
    ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = rd;
  endtask

  task automatic id_read1(input logic [2:0] rs, input logic br);
    id_valid = 1; id_rs1 = rs; id_use1 = 1; id_branch = br;
  endtask

  initial begin
    reset = 1;
    clr();
    nochk();

    // Reset gating on both instances with hazards and matches present
    jump_taken = 1; mem_valid = 1; mem_regwrite = 1; mem_rd = 3; ex_rs1 = 3;
    ex_load(3'd2); id_read1(3'd2, 1'b0);
    step("rst_u0", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);
    step("rst_u3", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);
    reset = 0;

    clr(); ex_rs1 = 3; ex_rs2 = 1; mem_valid = 1; mem_regwrite = 1; mem_rd = 3;
    wb_regwrite = 1; wb_rd = 3;
    step("fwd_mem_prio", 0, 2'b01, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);
    mem_regwrite = 0;
    step("fwd_wb", 0, 2'b10, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);
    mem_regwrite = 1; mem_memread = 1; ex_rs2 = 3;
    step("fwd_load_in_mem", 0, 2'b10, 2'b10, 2'b00, 2'b00, S_NONE, 16'd0);

    clr(); mem_valid = 1; mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 0;
    ex_load(3'd0); id_valid = 1; id_use2 = 1; id_rs2 = 0; id_branch = 1;
    step("zero_reg", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);

    clr(); id_rs1 = 5; id_rs2 = 6; mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
    wb_regwrite = 1; wb_rd = 6;
    step("bfwd_sel", 0, 2'b00, 2'b00, 2'b01, 2'b10, S_NONE, 16'd0);

    clr(); ex_load(3'd2); id_valid = 1; id_rs1 = 2; id_use2 = 1; id_rs2 = 7;
    step("lu_unused_src", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);
    id_use1 = 1;
    step("lu_stall", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd0);
    clr(); mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 2; id_read1(3'd2, 1'b0);
    step("lu_release", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd1);

    reset = 1; clr(); nochk(); reset = 0;

    // Load then dependent branch: two stall cycles, WB forward on release
    ex_load(3'd4); id_read1(3'd4, 1'b1);
    step("brld_cyc1", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd0);
    clr(); mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 4; id_read1(3'd4, 1'b1);
    step("brld_hold", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd1);
    clr(); wb_regwrite = 1; wb_rd = 4; id_read1(3'd4, 1'b1);
    step("brld_release", 0, 2'b00, 2'b00, 2'b10, 2'b00, S_NONE, 16'd2);

    clr(); ex_valid = 1; ex_regwrite = 1; ex_rd = 5;
    id_valid = 1; id_branch = 1; id_rs2 = 5; id_use2 = 1;
    step("brex_stall", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd2);
    ex_valid = 0; ex_regwrite = 0; ex_rd = 0; mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
    step("brex_release", 0, 2'b00, 2'b00, 2'b00, 2'b01, S_NONE, 16'd3);

    clr(); mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 6; id_read1(3'd6, 1'b1);
    step("brmem_stall", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd3);
    clr(); wb_regwrite = 1; wb_rd = 6; id_read1(3'd6, 1'b1);
    step("brmem_release", 0, 2'b00, 2'b00, 2'b10, 2'b00, S_NONE, 16'd4);

    clr(); jump_taken = 1;
    step("flush", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_FL, 16'd4);
    ex_load(3'd2); id_read1(3'd2, 1'b0);
    step("flush_blocked", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_HZ, 16'd4);
    clr();
    step("count_after", 0, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd5);

    reset = 1; clr(); nochk(); reset = 0;

    // MEM_LAT=3: store freezes three cycles, released on the fourth
    mem_valid = 1; mem_memwrite = 1;
    step("st_wait1", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd0);
    step("st_wait2", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd1);
    step("st_wait3", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd2);
    step("st_release", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd3);

    // Back-to-back load; a load-use hazard must not bubble while frozen
    clr(); mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 1;
    ex_load(3'd2); id_read1(3'd2, 1'b0);
    step("ld_wait1", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd3);
    step("ld_wait2", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd4);
    step("ld_wait3", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd5);
    clr(); mem_valid = 1; mem_regwrite = 1; mem_memread = 1; mem_rd = 1;
    step("ld_release", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd6);

    clr(); mem_valid = 1; mem_memwrite = 1;
    step("st2_wait1", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FRZ, 16'd6);
    reset = 1;
    step("rst_in_wait", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd7);
    reset = 0; clr(); jump_taken = 1;
    step("rst_abort_flush", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_FL, 16'd0);
    clr();
    step("idle_after_abort", 1, 2'b00, 2'b00, 2'b00, 2'b00, S_NONE, 16'd0);

    nochk();
    nochk();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the current forwarding unit of the 5-stage pipelined core (IF/ID/EX/MEM/WB).
- Generates EX-stage and decode-comparator forwarding selects, as today.
- Adds registered hazard control: load-use stalls, branch-in-decode dependency stalls, multi-cycle data-memory wait, IF/ID flush on taken jump, and a stall-cycle counter.
- Sits beside the stage modules in the CPU top; its outputs drive pipeline-register enables and the forwarding muxes.

Parameters:
RA_W, 3, register address width (bits)
MEM_LAT, 0, stall cycles per data-memory access (0..15); 0 removes wait logic
ZERO_REG, 0, 1 = register 0 hard-wired, never forwarded or hazard-matched

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds an instruction
id_rs1, id_rs2  in  RA_W each  ID source registers
id_use1, id_use2  in  1 each  ID actually reads rs1/rs2
id_branch  in  1  ID instruction compares in decode
jump_taken  in  1  decode resolved a taken branch/jump
ex_valid, ex_regwrite, ex_memread  in  1 each  EX status
ex_rs1, ex_rs2, ex_rd  in  RA_W each  EX registers
mem_valid, mem_regwrite, mem_memread, mem_memwrite  in  1 each  MEM status
mem_rd  in  RA_W  MEM destination
wb_regwrite  in  1  WB writes
wb_rd  in  RA_W  WB destination
fwd1_ex, fwd2_ex  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB data
bfwd1, bfwd2  out  2 each  decode comparator select, same encoding
stall_pc, stall_ifid  out  1 each  hold PC / IF-ID register
bubble_idex  out  1  load zeros into ID/EX control
stall_idex, stall_exmem  out  1 each  hold registers (memory wait only)
bubble_memwb  out  1  insert bubble into MEM/WB
flush_ifid  out  1  zero IF/ID
stall_count  out  16  saturating count of cycles with stall_pc=1

Behaviour:
- match(a,rd,we,v) = v & we & (a==rd) & ~(ZERO_REG & rd==0).
- Forwarding is combinational.
  - fwd1_ex: MEM match on ex_rs1 (mem_memread=0) -> 01; else WB match -> 10; else 00. fwd2_ex identical on ex_rs2. MEM has priority over WB.
  - bfwd1/bfwd2: same rule on id_rs1/id_rs2; a MEM match with mem_memread=1 gives 10 only via WB, else 00, and a stall is raised.
- Hazard detection (combinational), only in state RUN:
  - LU: ex_memread & match(id_rsN, ex_rd) with id_useN, any instruction -> 1 stall cycle.
  - BR_EX: id_branch & match(id_rsN, ex_rd), ex_memread=0 -> 1 stall cycle.
  - BR_LD: id_branch & ex_memread & match -> 2 stall cycles: this cycle, then state BR_HOLD for 1 cycle.
  - BR_MEM: id_branch & mem_memread & match(id_rsN, mem_rd) -> 1 stall cycle.
  - Any hazard stall: stall_pc=stall_ifid=bubble_idex=1.
- FSM states and transitions:
  - RUN -> BR_HOLD on BR_LD.
  - RUN -> MEM_WAIT on memory access (MEM_LAT>0, mem_valid & (mem_memread|mem_memwrite)).
  - BR_HOLD -> RUN after 1 cycle, re-evaluating BR_MEM that cycle.
  - MEM_WAIT -> RUN when cnt==0.
- Memory wait:
  - In the detection cycle, all of stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_memwb = 1; load cnt = MEM_LAT-1 and enter MEM_WAIT.
  - In MEM_WAIT, the same five outputs equal (cnt!=0); cnt decrements.
  - On the cnt==0 cycle all stalls are 0, the access completes, and the state returns to RUN. No retrigger is possible on that cycle.
  - Total freeze = exactly MEM_LAT cycles per access.
- Priority: memory wait > BR_HOLD > LU/BR hazards. bubble_idex=0 while memory-frozen.
- flush_ifid = jump_taken & ~stall_ifid.
- stall_count increments on every cycle with stall_pc=1 and saturates at 0xFFFF.
- Reset (synchronous):
  - State RUN, cnt=0, stall_count=0.
  - While reset=1, all stall/bubble/flush outputs = 0 and all fwd/bfwd = 00.
  - Reset mid-wait or mid-BR_HOLD aborts immediately; the next cycle after reset deasserts is RUN.

Test Plan:
- EX add r1 writes r3, MEM add writes r3, WB writes r3 -> fwd1_ex=01; with MEM regwrite=0 -> fwd1_ex=10.
- ZERO_REG=1, MEM writes r0, ex_rs2=0 -> fwd2_ex=00, no stall.
- EX load r2, ID add uses r2 -> exactly 1 cycle stall_pc=stall_ifid=bubble_idex=1, then 0; stall_count=1.
- EX load r4, ID branch reads r4 -> 2 stall cycles, then bfwd1=10 on release; stall_count=2.
- MEM_LAT=3, store reaches MEM -> stall_exmem=1 for 3 cycles, 0 on 4th; a back-to-back load then freezes another 3 cycles.
- Reset asserted during the 2nd MEM_WAIT cycle -> next cycle all stalls 0, state RUN, stall_count=0; jump_taken with no stall -> flush_ifid=1.
